// File: rtl/pll_reset_sequencer_if.sv
// pll_reset_sequencer_if
//   Bundles the PLL-side status/control and the reset/status outputs of the
//   PLL reset sequencer.
//   Signals:
//     pll_locked   PLL lock indication, asynchronous to the reference clock
//     restart_req  single-cycle pulse requesting a full re-sequence
//     pll_rst      active-high reset to the PLL
//     core_reset_n active-low reset to PLL-clocked logic
//     ready        high only while the PLL is locked and core logic is running
//     fault        high only after the retry budget is exhausted
//     retry_cnt    failed attempts since last restart/reset (saturating)
//     lost_cnt     lock-loss events seen while running (saturating)
//   Modports:
//     master  environment side: drives pll_locked/restart_req, observes status
//     slave   sequencer side: consumes pll_locked/restart_req, drives status
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       restart_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       ready;
  logic       fault;
  logic [2:0] retry_cnt;
  logic [7:0] lost_cnt;

  modport master (
    output pll_locked,
    output restart_req,
    input  pll_rst,
    input  core_reset_n,
    input  ready,
    input  fault,
    input  retry_cnt,
    input  lost_cnt
  );

  modport slave (
    input  pll_locked,
    input  restart_req,
    output pll_rst,
    output core_reset_n,
    output ready,
    output fault,
    output retry_cnt,
    output lost_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Brings up the core PLL: holds PLL reset for a fixed time, waits for lock,
//   requires lock to stay up for a qualification window and only then releases
//   the core-logic reset. Loss of lock while running re-runs the sequence;
//   lock timeouts are retried a bounded number of times before latching FAULT.
//   Runs on the PLL reference clock.
//   Ports:
//     clk_74a  reference clock (same source as the PLL refclk)
//     reset_n  asynchronous active-low reset
//     bus      pll_reset_sequencer_if.slave (lock/restart in, resets/status out)
module pll_reset_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES        = 4,
  parameter int unsigned CNT_W              = 17
) (
  input  logic                  clk_74a,
  input  logic                  reset_n,
  pll_reset_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  // Terminal counter values: each phase leaves its state on the edge where
  // the counter already holds the last value, so the counter never wraps.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       retry_q, retry_nx, retry_inc;
  logic [7:0]       lost_q, lost_nx, lost_inc;

  logic pll_rst_q;
  logic core_reset_n_q;
  logic ready_q;
  logic fault_q;

  // pll_locked comes from the PLL's own analogue lock detector and is not
  // related to clk_74a; only the second flop's output is ever used.
  logic lock_meta, lock_s;

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    retry_inc = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
    lost_inc  = (lost_q == '1) ? lost_q : lost_q + 8'd1;
  end

  // Next-state logic. restart_req is checked first so it overrides timeout
  // and lock-loss handling in the same cycle.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    retry_nx = retry_q;
    lost_nx  = lost_q;

    if (bus.restart_req) begin
      state_nx = S_RESET_PLL;
      cnt_nx   = '0;
      retry_nx = '0;
    end else begin
      unique case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end

        S_WAIT_LOCK: begin
          // Lock is tested before the timeout so a lock arriving on the
          // timeout cycle still counts.
          if (lock_s) begin
            state_nx = S_STABLE;
            cnt_nx   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_nx = retry_inc;
            state_nx = (32'(retry_inc) >= MAX_RETRIES) ? S_FAULT : S_RESET_PLL;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end

        S_STABLE: begin
          // A drop during qualification is treated as acquisition jitter:
          // go back to waiting without spending a retry.
          if (!lock_s) begin
            state_nx = S_WAIT_LOCK;
            cnt_nx   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_nx = S_RUN;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state_nx = S_RESET_PLL;
            cnt_nx   = '0;
            lost_nx  = lost_inc;
          end
        end

        S_FAULT: begin
          state_nx = S_FAULT;
        end

        default: begin
          state_nx = S_RESET_PLL;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge
  // as the state itself.
  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_RESET_PLL;
      cnt            <= '0;
      retry_q        <= '0;
      lost_q         <= '0;
      pll_rst_q      <= 1'b1;
      core_reset_n_q <= 1'b0;
      ready_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      retry_q        <= retry_nx;
      lost_q         <= lost_nx;
      pll_rst_q      <= (state_nx == S_RESET_PLL) || (state_nx == S_FAULT);
      core_reset_n_q <= (state_nx == S_RUN);
      ready_q        <= (state_nx == S_RUN);
      fault_q        <= (state_nx == S_FAULT);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.core_reset_n = core_reset_n_q;
  assign bus.ready        = ready_q;
  assign bus.fault        = fault_q;
  assign bus.retry_cnt    = retry_q;
  assign bus.lost_cnt     = lost_q;

endmodule
